aes_key_sched_ctrl: RTL
=======================

// Module: aes_key_sched_ctrl
// PURPOSE
//  Iterative AES-128 key-expansion controller: one key_schedule instance, reused over 10 cycles.
//  Produces the 11 round keys and holds them in an internal key store.
//  Serves them to the round datapath through a registered random-access read port.
//  Replaces the fully unrolled expansion when area matters; sits between key load and cipher core.
// PARAMETERS
//  NR     10   number of AES rounds; key store holds NR+1 entries
//  KEY_W  128  round-key width in bits
// PORTS
//  clk         in   1      single clock, all logic on posedge
//  rst         in   1      synchronous, active-high reset
//  key_in      in   KEY_W  cipher key, sampled on accept
//  key_valid   in   1      key_in valid
//  key_ready   out  1      controller can accept a key
//  busy        out  1      expansion in progress
//  keys_valid  out  1      all NR+1 round keys in store are valid
//  done        out  1      1-cycle pulse: expansion (or cache hit) complete
//  cache_hit   out  1      1-cycle pulse: key matched stored key (AES_KEY_CACHE_EN only)
//  rd_idx      in   4      round-key index 0..NR
//  rd_key      out  KEY_W  round key rd_idx, registered, valid 1 cycle after rd_idx
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset values: key_ready=1, busy=0, keys_valid=0, done=0, cache_hit=0, rd_key=0.
//    FSM=IDLE, round=0, rcon=8'h01, key store zeroed.
//  FSM states:
//    IDLE
//      key_ready=1.
//      Accept (key_valid&&key_ready): rk[0]<=key_in, round<=1, rcon<=8'h01, ->EXPAND.
//    EXPAND
//      key_ready=0, busy=1.
//      Each cycle: rk[round] <= key_schedule(rk[round-1], {rcon,24'h0}).
//      Then round<=round+1, rcon<=xtime(rcon), where xtime = (rcon<<1) ^ (rcon[7] ? 8'h1b : 0).
//      On the cycle writing rk[NR]: ->READY, done<=1.
//    READY
//      key_ready=1, keys_valid=1.
//      Accepting a new key behaves as in IDLE and drops keys_valid on the same edge.
//  Latency: key accepted on edge 0; rk[i] written on edge i; keys_valid and done visible after edge NR (10).
//  rcon sequence: 01,02,04,08,10,20,40,80,1b,36; 8-bit wrap handled by xtime.
//  Read port:
//    rd_key <= rk[rd_idx] every cycle; rd_idx > NR yields 0.
//    Reads during EXPAND return current store contents; they are defined only for indices already written.
//  key_valid during EXPAND is ignored (not accepted); the requester holds it until key_ready.
//  rst mid-EXPAND: aborts, store zeroed, next cycle IDLE with reset outputs.
//  done and cache_hit are never high on consecutive cycles without a new accept.
// CONFIGURATION
//  AES_KEY_CACHE_EN defined:
//    Accept in READY with key_in == rk[0]: skip expansion, stay READY, keys_valid stays 1.
//    done=1 and cache_hit=1 on the next cycle.
//  AES_KEY_CACHE_EN undefined:
//    Every accept re-expands (10 cycles).
//    No 128-bit comparator; cache_hit tied to 0.
// STRUCTURE
//  aes_pkg holds:
//    typedef logic [127:0] block_t; typedef logic [3:0] round_idx_t
//    localparam NR=10, RCON_INIT=8'h01
//    function xtime(logic [7:0])
//    typedef enum {IDLE, EXPAND, READY} ksc_state_t
//  One sub-module: existing key_schedule (combinational single round-key step), instantiated once.
//  Key store: block_t rk[0:NR] register array with one write port and one registered read port.
// TESTING
//  1 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c -> done after 10 cycles.
//    rk[1]=a0fafe1788542cb123a339392a6c7605; rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
//  2 Sweep rd_idx 0..15 after keys_valid -> rd_key matches rk[idx] one cycle later; idx 11..15 give 0.
//  3 key_valid held high during EXPAND with a different key -> ignored.
//    Accepted only at READY; second expansion uses the new key.
//  4 rst asserted at round 5 -> next cycle keys_valid=0, key_ready=1, rd_key=0, rd_idx=1 reads 0.
//    New key then expands correctly.
//  5 AES_KEY_CACHE_EN, same key re-submitted in READY -> done=cache_hit=1 after 1 cycle, busy never set.
//    Without the macro -> busy for 10 cycles, cache_hit=0.
//  6 All-zero and all-ones keys -> rk[10] equals a software reference model; rcon 80->1b wrap is exercised.

Source files
------------

// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared types, constants and GF(2^8) helper for the iterative AES-128 key-expansion controller.
package aes_key_sched_ctrl_pkg;

    localparam int unsigned NR        = 10;
    localparam int unsigned KEY_W     = 128;
    localparam logic [7:0]  RCON_INIT = 8'h01;

    typedef logic [127:0] block_t;
    typedef logic [3:0]   round_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } ksc_state_t;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_key_schedule.sv
// Combinational single AES-128 key-schedule step: derives round key i from round key i-1 and rcon.
module key_schedule
    import aes_key_sched_ctrl_pkg::*;
(
    input  logic [KEY_W-1:0] prev_key,
    input  logic [31:0]      rcon_word,
    output logic [KEY_W-1:0] next_key
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] sub_rot;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = prev_key[127:96];
    assign w1 = prev_key[95:64];
    assign w2 = prev_key[63:32];
    assign w3 = prev_key[31:0];

    assign sub_rot = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

    assign n0 = w0 ^ sub_rot ^ rcon_word;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-expansion controller with an 11-entry round-key store and registered read port.
// Optional build macro AES_KEY_CACHE_EN: re-submitting the stored key in READY skips re-expansion.
module aes_key_sched_ctrl
    import aes_key_sched_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic             busy,
    output logic             keys_valid,
    output logic             done,
    output logic             cache_hit,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key
);

    ksc_state_t state_q, state_d;
    round_idx_t round_q, round_d;
    logic [7:0] rcon_q, rcon_d;
    logic       done_d, cache_hit_d;
    logic       load_key, step_key;
    logic       accept;

    block_t     rk [0:NR];
    block_t     ks_out;
    round_idx_t prev_idx;

    assign accept   = key_valid && key_ready;
    assign prev_idx = round_q - 4'd1;

    key_schedule u_key_schedule (
        .prev_key  (rk[prev_idx]),
        .rcon_word ({rcon_q, 24'h000000}),
        .next_key  (ks_out)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        rcon_d      = rcon_q;
        done_d      = 1'b0;
        cache_hit_d = 1'b0;
        load_key    = 1'b0;
        step_key    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load_key = 1'b1;
                    round_d  = 4'd1;
                    rcon_d   = RCON_INIT;
                    state_d  = EXPAND;
                end
            end
            EXPAND: begin
                step_key = 1'b1;
                round_d  = round_q + 4'd1;
                rcon_d   = xtime(rcon_q);
                if (round_q == 4'(NR)) begin
                    state_d = READY;
                    done_d  = 1'b1;
                end
            end
            READY: begin
                if (accept) begin
`ifdef AES_KEY_CACHE_EN
                    if (key_in == rk[0]) begin
                        done_d      = 1'b1;
                        cache_hit_d = 1'b1;
                    end else begin
                        load_key = 1'b1;
                        round_d  = 4'd1;
                        rcon_d   = RCON_INIT;
                        state_d  = EXPAND;
                    end
`else
                    load_key = 1'b1;
                    round_d  = 4'd1;
                    rcon_d   = RCON_INIT;
                    state_d  = EXPAND;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, registered outputs and key store.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            round_q    <= 4'd0;
            rcon_q     <= RCON_INIT;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            done       <= 1'b0;
            cache_hit  <= 1'b0;
            rd_key     <= '0;
            for (int i = 0; i <= int'(NR); i++) begin
                rk[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            rcon_q     <= rcon_d;
            key_ready  <= (state_d != EXPAND);
            busy       <= (state_d == EXPAND);
            keys_valid <= (state_d == READY);
            done       <= done_d;
            cache_hit  <= cache_hit_d;
            if (load_key) rk[0] <= key_in;
            if (step_key) rk[round_q] <= ks_out;
            if (rd_idx <= 4'(NR)) rd_key <= rk[rd_idx];
            else                  rd_key <= '0;
        end
    end

endmodule
